// File: rtl/diffeq_operand_sender.sv
// rtl/diffeq_operand_sender.sv - host-side operand-load sequencer for the diffeq solver
// Restarts the solver, streams x/dx/a/u with one-hot strobes, then waits for and captures results.
module diffeq_operand_sender #(
    parameter int WIDTH          = 16,
    parameter int STROBE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] dx_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] u_in,
    input  logic [2:0]       solver_state,
    input  logic             solver_valid,
    input  logic [WIDTH-1:0] res_x,
    input  logic [WIDTH-1:0] res_y,
    input  logic [WIDTH-1:0] res_u,
    output logic             solver_reset,
    output logic [WIDTH-1:0] data_out,
    output logic             s1,
    output logic             s2,
    output logic             s3,
    output logic             s4,
    output logic             ready,
    output logic             busy,
    output logic [WIDTH-1:0] x_out,
    output logic [WIDTH-1:0] y_out,
    output logic [WIDTH-1:0] u_out,
    output logic             done,
    output logic             timeout
);

    localparam int CMAX = (TIMEOUT_CYCLES > STROBE_CYCLES) ? TIMEOUT_CYCLES : STROBE_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] STROBE_LAST  = CW'(STROBE_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]    SOLVER_READ  = 3'b001;

    typedef enum logic [3:0] {
        IDLE, RST, WAIT_READ, SEND_X, SEND_DX, SEND_A, SEND_U, ARM, WAIT_VALID, ERROR
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] x_reg;
    logic [WIDTH-1:0] dx_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] u_reg;
    logic             strobe_last;
    logic             watchdog_hit;

    // One counter serves both the strobe window and the per-wait-state watchdog.
    assign strobe_last  = (cnt == STROBE_LAST);
    assign watchdog_hit = (cnt == TIMEOUT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            x_reg        <= '0;
            dx_reg       <= '0;
            a_reg        <= '0;
            u_reg        <= '0;
            solver_reset <= 1'b0;
            data_out     <= '0;
            s1           <= 1'b0;
            s2           <= 1'b0;
            s3           <= 1'b0;
            s4           <= 1'b0;
            ready        <= 1'b0;
            busy         <= 1'b0;
            x_out        <= '0;
            y_out        <= '0;
            u_out        <= '0;
            done         <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            solver_reset <= 1'b0;
            done         <= 1'b0;
            case (state)
                IDLE, ERROR: begin
                    if (start) begin
                        x_reg        <= x_in;
                        dx_reg       <= dx_in;
                        a_reg        <= a_in;
                        u_reg        <= u_in;
                        timeout      <= 1'b0;
                        solver_reset <= 1'b1;
                        busy         <= 1'b1;
                        cnt          <= '0;
                        state        <= RST;
                    end
                end
                RST: begin
                    cnt   <= '0;
                    state <= WAIT_READ;
                end
                WAIT_READ: begin
                    if (solver_state == SOLVER_READ) begin
                        cnt      <= '0;
                        s1       <= 1'b1;
                        data_out <= x_reg;
                        state    <= SEND_X;
                    end else if (watchdog_hit) begin
                        cnt     <= '0;
                        busy    <= 1'b0;
                        timeout <= 1'b1;
                        state   <= ERROR;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                SEND_X: begin
                    if (strobe_last) begin
                        cnt      <= '0;
                        s1       <= 1'b0;
                        s2       <= 1'b1;
                        data_out <= dx_reg;
                        state    <= SEND_DX;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                SEND_DX: begin
                    if (strobe_last) begin
                        cnt      <= '0;
                        s2       <= 1'b0;
                        s3       <= 1'b1;
                        data_out <= a_reg;
                        state    <= SEND_A;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                SEND_A: begin
                    if (strobe_last) begin
                        cnt      <= '0;
                        s3       <= 1'b0;
                        s4       <= 1'b1;
                        data_out <= u_reg;
                        state    <= SEND_U;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                SEND_U: begin
                    if (strobe_last) begin
                        cnt      <= '0;
                        s4       <= 1'b0;
                        data_out <= '0;
                        ready    <= 1'b1;
                        state    <= ARM;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ARM: begin
                    // Ready is held until the solver acknowledges by leaving READ.
                    if (solver_state != SOLVER_READ) begin
                        cnt   <= '0;
                        ready <= 1'b0;
                        state <= WAIT_VALID;
                    end else if (watchdog_hit) begin
                        cnt     <= '0;
                        ready   <= 1'b0;
                        busy    <= 1'b0;
                        timeout <= 1'b1;
                        state   <= ERROR;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                WAIT_VALID: begin
                    if (solver_valid) begin
                        x_out <= res_x;
                        y_out <= res_y;
                        u_out <= res_u;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (watchdog_hit) begin
                        cnt     <= '0;
                        busy    <= 1'b0;
                        timeout <= 1'b1;
                        state   <= ERROR;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    cnt      <= '0;
                    s1       <= 1'b0;
                    s2       <= 1'b0;
                    s3       <= 1'b0;
                    s4       <= 1'b0;
                    data_out <= '0;
                    ready    <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
